// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word reads to instruction memory,
// absorbs multi-cycle latency with a four-state FSM and a one-entry buffer, and drives the IF/ID register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold_IF_reg,
    input  logic        reset_IF_reg,
    input  logic        branch_jump_signal,
    input  logic [31:0] branch_jump_target,
    output logic        i_mem_read,
    output logic [31:0] i_mem_address,
    input  logic [31:0] i_mem_readdata,
    input  logic        i_mem_busywait,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic        instr_valid,
    output logic        fetch_stall
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_BUFFER = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] target_reg, target_next;
    logic [31:0] buf_reg, buf_next;
    logic [31:0] instruction_reg, instruction_next;
    logic [31:0] if_pc_reg, if_pc_next;
    logic [31:0] if_pc_plus_4_reg, if_pc_plus_4_next;
    logic        instr_valid_reg, instr_valid_next;

    logic        accept;
    logic [31:0] accept_instr;
    logic [31:0] target_word;

    // Low address bits of a redirect are dropped so the PC stays word aligned.
    assign target_word = branch_jump_target & ~32'h0000_0003;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_FETCH;
            pc_reg           <= RESET_PC;
            target_reg       <= RESET_PC;
            buf_reg          <= 32'h0;
            instruction_reg  <= NOP_INSTR;
            if_pc_reg        <= RESET_PC;
            if_pc_plus_4_reg <= RESET_PC + 32'd4;
            instr_valid_reg  <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pc_reg           <= pc_next;
            target_reg       <= target_next;
            buf_reg          <= buf_next;
            instruction_reg  <= instruction_next;
            if_pc_reg        <= if_pc_next;
            if_pc_plus_4_reg <= if_pc_plus_4_next;
            instr_valid_reg  <= instr_valid_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        pc_next           = pc_reg;
        target_next       = target_reg;
        buf_next          = buf_reg;
        instruction_next  = instruction_reg;
        if_pc_next        = if_pc_reg;
        if_pc_plus_4_next = if_pc_plus_4_reg;
        instr_valid_next  = instr_valid_reg;
        accept            = 1'b0;
        accept_instr      = i_mem_readdata;

        case (state_reg)
            ST_FETCH: begin
                if (branch_jump_signal) begin
                    pc_next = target_word;
                end else if (!hold_IF_reg) begin
                    if (!i_mem_busywait) accept = 1'b1;
                    else                 state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (branch_jump_signal) begin
                    // An outstanding read must still be drained before the new target is issued.
                    if (i_mem_busywait) begin
                        target_next = target_word;
                        state_next  = ST_DRAIN;
                    end else begin
                        pc_next    = target_word;
                        state_next = ST_FETCH;
                    end
                end else if (!i_mem_busywait) begin
                    if (hold_IF_reg) begin
                        buf_next   = i_mem_readdata;
                        state_next = ST_BUFFER;
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_BUFFER: begin
                if (branch_jump_signal) begin
                    pc_next    = target_word;
                    state_next = ST_FETCH;
                end else if (!hold_IF_reg) begin
                    accept       = 1'b1;
                    accept_instr = buf_reg;
                    state_next   = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (branch_jump_signal) target_next = target_word;
                if (!i_mem_busywait) begin
                    pc_next    = branch_jump_signal ? target_word : target_reg;
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_FETCH;
        endcase

        if (accept) begin
            pc_next           = pc_reg + 32'd4;
            instruction_next  = accept_instr;
            if_pc_next        = pc_reg;
            if_pc_plus_4_next = pc_reg + 32'd4;
            instr_valid_next  = 1'b1;
        end

        // Flush wins over any accept or stall; the IF/ID PC fields keep their old value.
        if (branch_jump_signal || reset_IF_reg) begin
            instruction_next  = NOP_INSTR;
            instr_valid_next  = 1'b0;
            if_pc_next        = if_pc_reg;
            if_pc_plus_4_next = if_pc_plus_4_reg;
        end
    end

    always_comb begin
        i_mem_read  = 1'b0;
        fetch_stall = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                i_mem_read  = !hold_IF_reg && !branch_jump_signal;
                fetch_stall = i_mem_read && i_mem_busywait;
            end
            ST_WAIT: begin
                i_mem_read  = 1'b1;
                fetch_stall = 1'b1;
            end
            ST_BUFFER: begin
                i_mem_read  = 1'b0;
                fetch_stall = 1'b0;
            end
            ST_DRAIN: begin
                i_mem_read  = 1'b1;
                fetch_stall = 1'b1;
            end
            default: begin
                i_mem_read  = 1'b0;
                fetch_stall = 1'b0;
            end
        endcase
    end

    assign i_mem_address = pc_reg;
    assign instruction   = instruction_reg;
    assign pc            = if_pc_reg;
    assign pc_plus_4     = if_pc_plus_4_reg;
    assign instr_valid   = instr_valid_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory returns address + 0x100.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        hold_IF_reg;
    logic        reset_IF_reg;
    logic        branch_jump_signal;
    logic [31:0] branch_jump_target;
    logic        i_mem_read;
    logic [31:0] i_mem_address;
    logic [31:0] i_mem_readdata;
    logic        i_mem_busywait;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        instr_valid;
    logic        fetch_stall;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch_unit dut (
        .clk                (clk),
        .reset              (reset),
        .hold_IF_reg        (hold_IF_reg),
        .reset_IF_reg       (reset_IF_reg),
        .branch_jump_signal (branch_jump_signal),
        .branch_jump_target (branch_jump_target),
        .i_mem_read         (i_mem_read),
        .i_mem_address      (i_mem_address),
        .i_mem_readdata     (i_mem_readdata),
        .i_mem_busywait     (i_mem_busywait),
        .instruction        (instruction),
        .pc                 (pc),
        .pc_plus_4          (pc_plus_4),
        .instr_valid        (instr_valid),
        .fetch_stall        (fetch_stall)
    );

    assign i_mem_readdata = i_mem_address + 32'h0000_0100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-18s got=%08h exp=%08h ok", tag, got, exp);
        end else begin
            $display("FAIL %-18s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset              = 1'b1;
        hold_IF_reg        = 1'b0;
        reset_IF_reg       = 1'b0;
        branch_jump_signal = 1'b0;
        branch_jump_target = 32'h0;
        i_mem_busywait     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_instr", instruction, 32'h0000_0013);
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc_plus_4, 32'h4);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);

        // A: first cycle after release
        reset = 1'b0;
        #1;
        check("a_read", {31'b0, i_mem_read}, 32'h1);
        check("a_addr", i_mem_address, 32'h0);
        check("a_valid", {31'b0, instr_valid}, 32'h0);

        next_cycle(); // B
        #1;
        check("b_instr", instruction, 32'h0000_0100);
        check("b_pc", pc, 32'h0);
        check("b_pc4", pc_plus_4, 32'h4);
        check("b_valid", {31'b0, instr_valid}, 32'h1);
        check("b_addr", i_mem_address, 32'h4);

        next_cycle(); // C: memory goes busy at 0x8
        i_mem_busywait = 1'b1;
        #1;
        check("c_instr", instruction, 32'h0000_0104);
        check("c_pc", pc, 32'h4);
        check("c_addr", i_mem_address, 32'h8);
        check("c_stall", {31'b0, fetch_stall}, 32'h1);

        for (int i = 0; i < 2; i++) begin // D, E
            next_cycle();
            #1;
            check("de_stall", {31'b0, fetch_stall}, 32'h1);
            check("de_addr", i_mem_address, 32'h8);
        end

        next_cycle(); // F: memory ready
        i_mem_busywait = 1'b0;
        #1;
        check("f_addr", i_mem_address, 32'h8);
        check("f_instr_old", instruction, 32'h0000_0104);

        next_cycle(); // G
        i_mem_busywait = 1'b1;
        #1;
        check("g_instr", instruction, 32'h0000_0108);
        check("g_pc", pc, 32'h8);
        check("g_addr", i_mem_address, 32'hC);

        next_cycle(); // H: completion while held
        i_mem_busywait = 1'b0;
        hold_IF_reg    = 1'b1;
        #1;
        check("h_read", {31'b0, i_mem_read}, 32'h1);

        next_cycle(); // I: buffered, still held
        #1;
        check("i_read", {31'b0, i_mem_read}, 32'h0);
        check("i_stall", {31'b0, fetch_stall}, 32'h0);
        check("i_instr_frozen", instruction, 32'h0000_0108);
        check("i_addr", i_mem_address, 32'hC);

        next_cycle(); // J: release hold
        hold_IF_reg = 1'b0;

        next_cycle(); // K
        i_mem_busywait = 1'b1;
        #1;
        check("k_instr", instruction, 32'h0000_010C);
        check("k_pc", pc, 32'hC);
        check("k_addr", i_mem_address, 32'h10);
        check("k_valid", {31'b0, instr_valid}, 32'h1);

        next_cycle(); // L: redirect while waiting
        branch_jump_signal = 1'b1;
        branch_jump_target = 32'h0000_0040;

        next_cycle(); // M: draining
        branch_jump_signal = 1'b0;
        #1;
        check("m_addr", i_mem_address, 32'h10);
        check("m_read", {31'b0, i_mem_read}, 32'h1);
        check("m_stall", {31'b0, fetch_stall}, 32'h1);
        check("m_instr", instruction, 32'h0000_0013);
        check("m_valid", {31'b0, instr_valid}, 32'h0);
        check("m_pc", pc, 32'hC);

        next_cycle(); // N: drain completes
        i_mem_busywait = 1'b0;
        #1;
        check("n_addr", i_mem_address, 32'h10);

        next_cycle(); // O
        #1;
        check("o_addr", i_mem_address, 32'h40);
        check("o_valid", {31'b0, instr_valid}, 32'h0);
        check("o_read", {31'b0, i_mem_read}, 32'h1);

        next_cycle(); // P: flush together with hold
        hold_IF_reg  = 1'b1;
        reset_IF_reg = 1'b1;
        #1;
        check("p_instr", instruction, 32'h0000_0140);
        check("p_pc", pc, 32'h40);
        check("p_read", {31'b0, i_mem_read}, 32'h0);

        next_cycle(); // Q
        hold_IF_reg  = 1'b0;
        reset_IF_reg = 1'b0;
        #1;
        check("q_instr", instruction, 32'h0000_0013);
        check("q_valid", {31'b0, instr_valid}, 32'h0);
        check("q_pc", pc, 32'h40);
        check("q_addr", i_mem_address, 32'h44);

        next_cycle(); // R: redirect to top of address space
        branch_jump_signal = 1'b1;
        branch_jump_target = 32'hFFFF_FFFF;
        #1;
        check("r_instr", instruction, 32'h0000_0144);
        check("r_read", {31'b0, i_mem_read}, 32'h0);

        next_cycle(); // S
        branch_jump_signal = 1'b0;
        #1;
        check("s_addr", i_mem_address, 32'hFFFF_FFFC);
        check("s_valid", {31'b0, instr_valid}, 32'h0);

        next_cycle(); // T
        #1;
        check("t_instr", instruction, 32'h0000_00FC);
        check("t_pc", pc, 32'hFFFF_FFFC);
        check("t_pc4_wrap", pc_plus_4, 32'h0);
        check("t_addr_wrap", i_mem_address, 32'h0);

        next_cycle(); // U
        i_mem_busywait = 1'b1;
        #1;
        check("u_instr", instruction, 32'h0000_0100);
        check("u_pc", pc, 32'h0);
        check("u_stall", {31'b0, fetch_stall}, 32'h1);

        next_cycle(); // V: reset asserted mid-WAIT
        i_mem_busywait = 1'b0;
        reset          = 1'b1;
        #1;
        check("v_instr", instruction, 32'h0000_0013);
        check("v_valid", {31'b0, instr_valid}, 32'h0);
        check("v_pc", pc, 32'h0);
        check("v_addr", i_mem_address, 32'h0);
        check("v_stall", {31'b0, fetch_stall}, 32'h0);

        next_cycle();
        reset = 1'b0;
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
